// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: the NOP encoding, the reset PC
// and the layout of the decode control bundle carried from D to E.
package core_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          CTRL_W           = 12;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic [3:0] alu_control;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       rsvd;
   } ctrl_t;

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}};

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: asynchronous reset, synchronous clear that
// overrides the enable, and a load enable.
module pipe_reg #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = {W{1'b0}},
   parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Storage with clear > enable > hold priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RST_VAL;
      end else if (clr) begin
         q <= CLR_VAL;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC register plus IF/ID and ID/EX pipeline registers, steered by the hazard
// unit's stall/flush commands, with saturating stall/flush event counters.
module pipe_stage_regs
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
   parameter int          CTRL_W   = core_pkg::CTRL_W,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stallf,
   input  logic              stalld,
   input  logic              flushd,
   input  logic              flushe,
   input  logic [31:0]       pcnext_f,
   input  logic [31:0]       instr_f,
   input  logic [31:0]       pcplus4_f,
   output logic [31:0]       pc_f,
   output logic [31:0]       instr_d,
   output logic [31:0]       pc_d,
   output logic [31:0]       pcplus4_d,
   output logic              valid_d,
   input  logic [31:0]       rd1_d,
   input  logic [31:0]       rd2_d,
   input  logic [31:0]       immext_d,
   input  logic [4:0]        rs1_d,
   input  logic [4:0]        rs2_d,
   input  logic [4:0]        rd_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   output logic [31:0]       rd1_e,
   output logic [31:0]       rd2_e,
   output logic [31:0]       immext_e,
   output logic [31:0]       pc_e,
   output logic [31:0]       pcplus4_e,
   output logic [4:0]        rs1_e,
   output logic [4:0]        rs2_e,
   output logic [4:0]        rd_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic              valid_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int IFID_W = 1 + 32 + 32 + 32;
   localparam int IDEX_W = 5 * 32 + 3 * 5 + CTRL_W + 1;

   // A flushed IF/ID slot looks exactly like the reset state: an invalid NOP.
   localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, 32'h0000_0000, 32'h0000_0000, NOP_INSTR};

   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;
   logic [IDEX_W-1:0] idex_d;
   logic [IDEX_W-1:0] idex_q;

   pipe_reg #(
      .W       (32),
      .RST_VAL (RESET_PC),
      .CLR_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .en    (~stallf),
      .d     (pcnext_f),
      .q     (pc_f)
   );

   assign ifid_d = {1'b1, pcplus4_f, pc_f, instr_f};

   pipe_reg #(
      .W       (IFID_W),
      .RST_VAL (IFID_BUBBLE),
      .CLR_VAL (IFID_BUBBLE)
   ) u_ifid_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (flushd),
      .en    (~stalld),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign {valid_d, pcplus4_d, pc_d, instr_d} = ifid_q;

   // ID/EX never stalls; a bubble carries all-zero control, so nothing is written.
   assign idex_d = {valid_d, ctrl_d, rd_d, rs2_d, rs1_d,
                    pcplus4_d, pc_d, immext_d, rd2_d, rd1_d};

   pipe_reg #(
      .W       (IDEX_W),
      .RST_VAL ({IDEX_W{1'b0}}),
      .CLR_VAL ({IDEX_W{1'b0}})
   ) u_idex_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (flushe),
      .en    (1'b1),
      .d     (idex_d),
      .q     (idex_q)
   );

   assign {valid_e, ctrl_e, rd_e, rs2_e, rs1_e,
           pcplus4_e, pc_e, immext_e, rd2_e, rd1_e} = idex_q;

   // Stall event counter, sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= {CNT_W{1'b0}};
      end else if (stallf && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

   // Flush event counter, sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_cnt <= {CNT_W{1'b0}};
      end else if (flushd && (flush_cnt != {CNT_W{1'b1}})) begin
         flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
         flush_cnt <= flush_cnt;
      end
   end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs: reset, sequential fetch,
// load-use stall, taken branch, flush-over-stall, counter saturation, mid-stall reset.
module tb_pipe_stage_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stallf = 1'b0;
   logic        stalld = 1'b0;
   logic        flushd = 1'b0;
   logic        flushe = 1'b0;
   logic        take = 1'b0;
   logic [31:0] target = 32'h0000_0000;
   logic [31:0] pcnext_f, instr_f, pcplus4_f, pc_f;
   logic [31:0] instr_d, pc_d, pcplus4_d;
   logic        valid_d;
   logic [31:0] rd1_d, rd2_d, immext_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [11:0] ctrl_d;
   logic [31:0] rd1_e, rd2_e, immext_e, pc_e, pcplus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [11:0] ctrl_e;
   logic        valid_e;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] pc);
      return {pc[15:0], 16'h0513};
   endfunction

   assign pcplus4_f = pc_f + 32'd4;
   assign pcnext_f  = take ? target : pcplus4_f;
   assign instr_f   = imem(pc_f);
   assign rd1_d     = pc_d + 32'h0000_0100;
   assign rd2_d     = pc_d + 32'h0000_0200;
   assign immext_d  = ~pc_d;
   assign rs1_d     = 5'd1;
   assign rs2_d     = 5'd2;
   assign rd_d      = 5'd3;
   assign ctrl_d    = 12'hA5B;

   pipe_stage_regs dut (
      .clk(clk), .reset(reset), .stallf(stallf), .stalld(stalld),
      .flushd(flushd), .flushe(flushe), .pcnext_f(pcnext_f),
      .instr_f(instr_f), .pcplus4_f(pcplus4_f), .pc_f(pc_f),
      .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .ctrl_d(ctrl_d),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e), .pc_e(pc_e),
      .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .ctrl_e(ctrl_e), .valid_e(valid_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // stallf without stalld is an illegal hazard-unit command.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(stallf && !stalld))
            else $error("illegal command: stallf=1 with stalld=0");
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check_val("rst_pc_f", pc_f, 32'h0000_0000);
      check_val("rst_instr_d", instr_d, NOP);
      check_val("rst_valid_d", {31'd0, valid_d}, 32'd0);
      check_val("rst_valid_e", {31'd0, valid_e}, 32'd0);
      check_val("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
      repeat (2) tick();
      check_val("rst_ctrl_e_clk", {20'd0, ctrl_e}, 32'd0);
      check_val("rst_pc_f_clk", pc_f, 32'h0000_0000);
      reset = 1'b0;
      check_val("pre_load_valid_d", {31'd0, valid_d}, 32'd0);

      tick();
      check_val("e1_pc_f", pc_f, 32'h0000_0004);
      check_val("e1_pc_d", pc_d, 32'h0000_0000);
      check_val("e1_instr_d", instr_d, imem(32'h0000_0000));
      check_val("e1_valid_d", {31'd0, valid_d}, 32'd1);
      check_val("e1_valid_e", {31'd0, valid_e}, 32'd0);
      tick();
      check_val("e2_pc_f", pc_f, 32'h0000_0008);
      check_val("e2_valid_e", {31'd0, valid_e}, 32'd1);
      check_val("e2_ctrl_e", {20'd0, ctrl_e}, 32'h0000_0A5B);
      check_val("e2_rd1_e", rd1_e, 32'h0000_0100);
      check_val("e2_immext_e", immext_e, 32'hFFFF_FFFF);
      check_val("e2_pcplus4_e", pcplus4_e, 32'h0000_0004);
      check_val("e2_regs_e", {17'd0, rs1_e, rs2_e, rd_e}, {17'd0, 5'd1, 5'd2, 5'd3});
      tick();
      check_val("e3_pc_f", pc_f, 32'h0000_000C);
      check_val("e3_pc_d", pc_d, 32'h0000_0008);

      // Load-use with the instruction at 0x8 sitting in D.
      stallf = 1'b1; stalld = 1'b1; flushe = 1'b1;
      tick();
      stallf = 1'b0; stalld = 1'b0; flushe = 1'b0;
      check_val("lu_pc_f_hold", pc_f, 32'h0000_000C);
      check_val("lu_instr_d_hold", instr_d, imem(32'h0000_0008));
      check_val("lu_valid_e", {31'd0, valid_e}, 32'd0);
      check_val("lu_ctrl_e", {20'd0, ctrl_e}, 32'd0);
      check_val("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
      tick();
      check_val("lu_pc_e", pc_e, 32'h0000_0008);
      check_val("lu_valid_e_next", {31'd0, valid_e}, 32'd1);
      check_val("lu_pc_f_next", pc_f, 32'h0000_0010);

      // Taken branch to 0x40.
      take = 1'b1; target = 32'h0000_0040; flushd = 1'b1; flushe = 1'b1;
      tick();
      take = 1'b0; flushd = 1'b0; flushe = 1'b0;
      check_val("br_pc_f", pc_f, 32'h0000_0040);
      check_val("br_valid_d", {31'd0, valid_d}, 32'd0);
      check_val("br_valid_e", {31'd0, valid_e}, 32'd0);
      check_val("br_instr_d", instr_d, NOP);
      check_val("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
      tick();
      check_val("br2_pc_d", pc_d, 32'h0000_0040);
      check_val("br2_valid_e", {31'd0, valid_e}, 32'd0);

      // Flush and stall of IF/ID together: flush wins.
      flushd = 1'b1; stalld = 1'b1;
      tick();
      flushd = 1'b0; stalld = 1'b0;
      check_val("fs_valid_d", {31'd0, valid_d}, 32'd0);
      check_val("fs_pc_d", pc_d, 32'h0000_0000);
      check_val("fs_pc_e", pc_e, 32'h0000_0040);
      check_val("fs_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd2});

      // Jump to 0x20, stall there, then reset in the middle of the stall.
      take = 1'b1; target = 32'h0000_0020;
      tick();
      take = 1'b0;
      check_val("jmp_pc_f", pc_f, 32'h0000_0020);
      stallf = 1'b1; stalld = 1'b1;
      repeat (2) tick();
      check_val("st_pc_f_hold", pc_f, 32'h0000_0020);
      check_val("st_stall_cnt", {16'd0, stall_cnt}, 32'd3);
      #2 reset = 1'b1;
      #1;
      check_val("mid_rst_pc_f", pc_f, 32'h0000_0000);
      check_val("mid_rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
      check_val("mid_rst_valid", {30'd0, valid_d, valid_e}, 32'd0);
      tick();
      reset = 1'b0; stallf = 1'b0; stalld = 1'b0;
      tick();
      check_val("post_rst_pc_f1", pc_f, 32'h0000_0004);
      tick();
      check_val("post_rst_pc_f2", pc_f, 32'h0000_0008);

      // Long stall saturates the stall counter.
      stallf = 1'b1; stalld = 1'b1;
      repeat (65534) tick();
      check_val("sat_pre", {16'd0, stall_cnt}, 32'h0000_FFFE);
      tick();
      check_val("sat_hit", {16'd0, stall_cnt}, 32'h0000_FFFF);
      repeat (4465) tick();
      check_val("sat_stick", {16'd0, stall_cnt}, 32'h0000_FFFF);
      check_val("sat_pc_f_hold", pc_f, 32'h0000_0008);
      check_val("sat_flush_cnt", {16'd0, flush_cnt}, 32'd0);
      stallf = 1'b0; stalld = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
